// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side): decodes MDC/MDIO frames and serves a small
// register set. All sampling and bus changes happen on the synchronised MDC rising strobe.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int          PRE_LEN  = 32,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1556,
    parameter logic [15:0] CTRL_RST = 16'h1140
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        mdio_mdc,
    input  logic        mdio_mdio_in,
    output logic        mdio_mdio_out,
    output logic        mdio_mdio_oen,
    input  logic [15:0] status_in,
    output logic [15:0] ctrl_out,
    output logic        wr_pulse,
    output logic [4:0]  wr_regad,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    localparam int CNT_W = $clog2(PRE_LEN + 1);
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PRE_LEN);

    typedef enum logic [3:0] {
        S_PRE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_RD, S_WR, S_SKIP
    } state_t;

    state_t            state_r;
    logic [2:0]        mdc_sync_r;
    logic [1:0]        mdio_sync_r;
    logic [CNT_W-1:0]  pre_cnt_r;
    logic [4:0]        bit_cnt_r;
    logic              op_hi_r;
    logic              is_read_r;
    logic [4:0]        phyad_r;
    logic [4:0]        regad_r;
    logic [15:0]       shift_r;
    logic [15:0]       ctrl_r;
    logic [15:0]       scratch_r [4];
    logic              out_r;
    logic              oen_r;
    logic              wr_pulse_r;
    logic [4:0]        wr_regad_r;
    logic [15:0]       wr_data_r;
    logic              frame_err_r;

    logic              strobe_s;
    logic              bit_s;
    logic [4:0]        regad_full_s;
    logic [15:0]       wr_word_s;
    logic [15:0]       rd_word_s;

    // Pin synchronisers; the third MDC flop is the previous value for edge detection
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mdc_sync_r  <= 3'b000;
            mdio_sync_r <= 2'b11;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[1:0], mdio_mdc};
            mdio_sync_r <= {mdio_sync_r[0], mdio_mdio_in};
        end
    end

    // Strobe, current MDIO bit and the words assembled from it
    always_comb begin
        strobe_s     = mdc_sync_r[1] & ~mdc_sync_r[2];
        bit_s        = mdio_sync_r[1];
        regad_full_s = {regad_r[3:0], bit_s};
        wr_word_s    = {shift_r[14:0], bit_s};
    end

    // Read mux, evaluated against the REGAD as it completes
    always_comb begin
        rd_word_s = 16'h0000;
        case (regad_full_s)
            5'd0:                    rd_word_s = ctrl_r;
            5'd1:                    rd_word_s = status_in;
            5'd2:                    rd_word_s = PHY_ID1;
            5'd3:                    rd_word_s = PHY_ID2;
            5'd4, 5'd5, 5'd6, 5'd7:  rd_word_s = scratch_r[regad_full_s[1:0]];
            default:                 rd_word_s = 16'h0000;
        endcase
    end

    // Frame FSM, register file and registered outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_r     <= S_PRE;
            pre_cnt_r   <= '0;
            bit_cnt_r   <= 5'd0;
            op_hi_r     <= 1'b0;
            is_read_r   <= 1'b0;
            phyad_r     <= 5'd0;
            regad_r     <= 5'd0;
            shift_r     <= 16'h0000;
            ctrl_r      <= CTRL_RST;
            for (int i = 0; i < 4; i++) begin
                scratch_r[i] <= 16'h0000;
            end
            out_r       <= 1'b1;
            oen_r       <= 1'b1;
            wr_pulse_r  <= 1'b0;
            wr_regad_r  <= 5'd0;
            wr_data_r   <= 16'h0000;
            frame_err_r <= 1'b0;
        end else begin
            wr_pulse_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (strobe_s) begin
                case (state_r)
                    S_PRE: begin
                        if (bit_s) begin
                            if (pre_cnt_r < PRE_MAX) begin
                                pre_cnt_r <= pre_cnt_r + CNT_W'(1);
                            end
                        end else begin
                            pre_cnt_r <= '0;
                            if (pre_cnt_r >= PRE_MAX) begin
                                state_r <= S_ST2;
                            end
                        end
                    end
                    S_ST2: begin
                        bit_cnt_r <= 5'd0;
                        if (bit_s) begin
                            state_r <= S_OP;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= S_PRE;
                        end
                    end
                    S_OP: begin
                        if (bit_cnt_r == 5'd0) begin
                            op_hi_r   <= bit_s;
                            bit_cnt_r <= 5'd1;
                        end else begin
                            bit_cnt_r <= 5'd0;
                            if (op_hi_r != bit_s) begin
                                is_read_r <= op_hi_r;
                                state_r   <= S_PHYAD;
                            end else begin
                                frame_err_r <= 1'b1;
                                state_r     <= S_PRE;
                            end
                        end
                    end
                    S_PHYAD: begin
                        phyad_r <= {phyad_r[3:0], bit_s};
                        if (bit_cnt_r == 5'd4) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_REGAD;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_REGAD: begin
                        regad_r <= regad_full_s;
                        if (bit_cnt_r == 5'd4) begin
                            bit_cnt_r <= 5'd0;
                            shift_r   <= rd_word_s;
                            state_r   <= (phyad_r == PHY_ADDR) ? S_TA : S_SKIP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_TA: begin
                        if (bit_cnt_r == 5'd0) begin
                            bit_cnt_r <= 5'd1;
                        end else begin
                            bit_cnt_r <= 5'd0;
                            if (is_read_r) begin
                                oen_r   <= 1'b0;
                                out_r   <= 1'b0;
                                state_r <= S_RD;
                            end else begin
                                state_r <= S_WR;
                            end
                        end
                    end
                    S_RD: begin
                        if (bit_cnt_r == 5'd16) begin
                            bit_cnt_r <= 5'd0;
                            oen_r     <= 1'b1;
                            out_r     <= 1'b1;
                            state_r   <= S_PRE;
                        end else begin
                            out_r     <= shift_r[15];
                            shift_r   <= {shift_r[14:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_WR: begin
                        shift_r <= wr_word_s;
                        if (bit_cnt_r == 5'd15) begin
                            bit_cnt_r  <= 5'd0;
                            wr_pulse_r <= 1'b1;
                            wr_regad_r <= regad_r;
                            wr_data_r  <= wr_word_s;
                            state_r    <= S_PRE;
                            case (regad_r)
                                5'd0:                   ctrl_r <= wr_word_s;
                                5'd4, 5'd5, 5'd6, 5'd7: scratch_r[regad_r[1:0]] <= wr_word_s;
                                default:                ;
                            endcase
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    S_SKIP: begin
                        if (bit_cnt_r == 5'd17) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_PRE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                    default: begin
                        state_r   <= S_PRE;
                        pre_cnt_r <= '0;
                        bit_cnt_r <= 5'd0;
                        oen_r     <= 1'b1;
                        out_r     <= 1'b1;
                    end
                endcase
            end
            // Placed last so the self-clear overrides a coinciding commit
            if (ctrl_r[15]) begin
                ctrl_r <= CTRL_RST;
            end
        end
    end

    assign mdio_mdio_out = out_r;
    assign mdio_mdio_oen = oen_r;
    assign ctrl_out      = ctrl_r;
    assign wr_pulse      = wr_pulse_r;
    assign wr_regad      = wr_regad_r;
    assign wr_data       = wr_data_r;
    assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: acts as MDIO master with an open-drain bus
// model, expected read words and write commits are queued at stimulus time.
module tb_mdio_phy_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdc = 1'b0;
    logic        m_drive = 1'b0;
    logic        m_val = 1'b1;
    logic        mdio_pin;
    logic        mdio_out;
    logic        mdio_oen;
    logic [15:0] status_in = 16'h0000;
    logic [15:0] ctrl_out;
    logic        wr_pulse;
    logic [4:0]  wr_regad;
    logic [15:0] wr_data;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int ctrl_hi_cnt = 0;
    logic drove_seen = 1'b0;

    logic [15:0] rd_q [$];
    logic [20:0] wr_q [$];

    always #5 clk = ~clk;

    // Pulled-up bus: the DUT wins when enabled, otherwise the master or the pull-up
    assign mdio_pin = (!mdio_oen) ? mdio_out : (m_drive ? m_val : 1'b1);

    mdio_phy_responder dut (
        .clk_clk      (clk),
        .reset_reset  (reset),
        .mdio_mdc     (mdc),
        .mdio_mdio_in (mdio_pin),
        .mdio_mdio_out(mdio_out),
        .mdio_mdio_oen(mdio_oen),
        .status_in    (status_in),
        .ctrl_out     (ctrl_out),
        .wr_pulse     (wr_pulse),
        .wr_regad     (wr_regad),
        .wr_data      (wr_data),
        .frame_err    (frame_err)
    );

    // Write-commit scoreboard and event counters
    always @(negedge clk) begin
        if (!mdio_oen) drove_seen = 1'b1;
        if (frame_err) err_cnt = err_cnt + 1;
        if (ctrl_out == 16'h9140) ctrl_hi_cnt = ctrl_hi_cnt + 1;
        if (wr_pulse) begin
            wr_cnt = wr_cnt + 1;
            vectors = vectors + 1;
            if (wr_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL wr_commit: unexpected wr_pulse regad=%0d data=%h, required none", wr_regad, wr_data);
            end else begin
                logic [20:0] e;
                e = wr_q.pop_front();
                if ({wr_regad, wr_data} !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL wr_commit: got regad=%0d data=%h, required regad=%0d data=%h",
                             wr_regad, wr_data, e[20:16], e[15:0]);
                end
            end
        end
    end

    task automatic mdc_cycle(input logic drv, input logic val);
        mdc = 1'b0;
        m_drive = drv;
        m_val = val;
        repeat (8) @(posedge clk);
        mdc = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic header(input int pre_n, input logic [1:0] op, input logic [4:0] phyad, input logic [4:0] regad);
        logic [13:0] bits;
        mdc_cycle(1'b1, 1'b0);
        for (int i = 0; i < pre_n; i++) mdc_cycle(1'b1, 1'b1);
        bits = {2'b01, op, phyad, regad};
        for (int i = 13; i >= 0; i--) mdc_cycle(1'b1, bits[i]);
    endtask

    task automatic read_frame(input int pre_n, input logic [4:0] phyad, input logic [4:0] regad, input int nbits,
                              output logic [15:0] data, output logic ta_ok, output logic rel_ok);
        logic o0;
        header(pre_n, 2'b10, phyad, regad);
        mdc_cycle(1'b0, 1'b0);
        o0 = mdio_oen;
        mdc_cycle(1'b0, 1'b0);
        ta_ok = o0 && !mdio_oen && !mdio_out;
        data = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            mdc_cycle(1'b0, 1'b0);
            data[15-i] = mdio_out;
        end
        rel_ok = 1'b0;
        if (nbits == 16) begin
            mdc_cycle(1'b0, 1'b0);
            rel_ok = mdio_oen && mdio_out;
        end
    endtask

    task automatic write_frame(input int pre_n, input logic [1:0] op, input logic [4:0] phyad, input logic [4:0] regad,
                               input logic [15:0] data, input int nbits);
        header(pre_n, op, phyad, regad);
        mdc_cycle(1'b1, 1'b1);
        mdc_cycle(1'b1, 1'b0);
        for (int i = 0; i < nbits; i++) mdc_cycle(1'b1, data[15-i]);
        if (nbits == 16) mdc_cycle(1'b1, 1'b1);
        m_drive = 1'b0;
    endtask

    task automatic reset_pulse();
        mdc = 1'b0;
        m_drive = 1'b0;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string name, input logic [4:0] phyad, input logic [4:0] regad, input logic [15:0] exp);
        logic [15:0] got, e;
        logic ta_ok, rel_ok;
        rd_q.push_back(exp);
        read_frame(32, phyad, regad, 16, got, ta_ok, rel_ok);
        e = rd_q.pop_front();
        vectors = vectors + 1;
        if (got !== e || !ta_ok || !rel_ok) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: data=%h ta_ok=%b rel_ok=%b, required data=%h ta_ok=1 rel_ok=1", name, got, ta_ok, rel_ok, e);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        vectors = vectors + 1;
        if ({mdio_out, mdio_oen, ctrl_out, wr_pulse, wr_regad, wr_data, frame_err} !==
            {1'b1, 1'b1, 16'h1140, 1'b0, 5'd0, 16'h0000, 1'b0}) begin
            miscompares = miscompares + 1;
            $display("FAIL reset_state: out=%b oen=%b ctrl=%h wp=%b regad=%0d wdata=%h ferr=%b, required 1 1 1140 0 0 0000 0",
                     mdio_out, mdio_oen, ctrl_out, wr_pulse, wr_regad, wr_data, frame_err);
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_write_read();
        int c0;
        c0 = wr_cnt;
        wr_q.push_back({5'd4, 16'hA55A});
        write_frame(32, 2'b01, 5'd1, 5'd4, 16'hA55A, 16);
        vectors = vectors + 1;
        if (wr_cnt - c0 != 1) begin
            miscompares = miscompares + 1;
            $display("FAIL write_pulse_count: got %0d, required 1", wr_cnt - c0);
        end
        check_read("read_reg4", 5'd1, 5'd4, 16'hA55A);
    endtask

    task automatic test_id_status();
        check_read("read_id1", 5'd1, 5'd2, 16'h0022);
        check_read("read_id2", 5'd1, 5'd3, 16'h1556);
        status_in = 16'h796D;
        check_read("read_status", 5'd1, 5'd1, 16'h796D);
        status_in = 16'h0000;
        check_read("read_reg20", 5'd1, 5'd20, 16'h0000);
    endtask

    task automatic test_ctrl_selfclear();
        ctrl_hi_cnt = 0;
        wr_q.push_back({5'd0, 16'h9140});
        write_frame(32, 2'b01, 5'd1, 5'd0, 16'h9140, 16);
        vectors = vectors + 1;
        if (ctrl_hi_cnt != 1 || ctrl_out !== 16'h1140) begin
            miscompares = miscompares + 1;
            $display("FAIL ctrl_selfclear: 9140 for %0d clk, now %h; required 1 clk, now 1140", ctrl_hi_cnt, ctrl_out);
        end
    endtask

    task automatic test_foreign_phy();
        logic [15:0] d;
        logic t, r;
        drove_seen = 1'b0;
        read_frame(32, 5'd5, 5'd4, 16, d, t, r);
        vectors = vectors + 1;
        if (drove_seen !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL foreign_phy_drive: drove=%b, required 0", drove_seen);
        end
        check_read("read_after_foreign", 5'd1, 5'd4, 16'hA55A);
    endtask

    task automatic test_short_preamble();
        logic [15:0] d;
        logic t, r;
        drove_seen = 1'b0;
        read_frame(31, 5'd1, 5'd4, 16, d, t, r);
        vectors = vectors + 1;
        if (drove_seen !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL short_preamble_drive: drove=%b, required 0", drove_seen);
        end
    endtask

    task automatic test_bad_op();
        int e0, c0;
        e0 = err_cnt;
        c0 = wr_cnt;
        drove_seen = 1'b0;
        write_frame(32, 2'b11, 5'd1, 5'd6, 16'h0000, 16);
        vectors = vectors + 1;
        if (err_cnt - e0 != 1 || drove_seen !== 1'b0 || wr_cnt != c0) begin
            miscompares = miscompares + 1;
            $display("FAIL bad_op: frame_err=%0d drove=%b writes=%0d, required 1 0 0", err_cnt - e0, drove_seen, wr_cnt - c0);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] d;
        logic t, r;
        read_frame(32, 5'd1, 5'd4, 7, d, t, r);
        vectors = vectors + 1;
        if (mdio_oen !== 1'b0 || d[15:9] !== 7'b1010010) begin
            miscompares = miscompares + 1;
            $display("FAIL mid_read_drive: oen=%b bits=%b, required oen=0 bits=1010010", mdio_oen, d[15:9]);
        end
        reset_pulse();
        vectors = vectors + 1;
        if (mdio_oen !== 1'b1 || mdio_out !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL reset_release: oen=%b out=%b, required 1 1", mdio_oen, mdio_out);
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_mid_write();
        int c0;
        wr_q.push_back({5'd5, 16'h1234});
        write_frame(32, 2'b01, 5'd1, 5'd5, 16'h1234, 16);
        check_read("read_reg5_before", 5'd1, 5'd5, 16'h1234);
        reset_pulse();
        reset = 1'b0;
        repeat (4) @(posedge clk);
        c0 = wr_cnt;
        write_frame(32, 2'b01, 5'd1, 5'd5, 16'hBEEF, 10);
        reset_pulse();
        reset = 1'b0;
        repeat (4) @(posedge clk);
        vectors = vectors + 1;
        if (wr_cnt != c0) begin
            miscompares = miscompares + 1;
            $display("FAIL partial_write_pulse: got %0d pulses, required 0", wr_cnt - c0);
        end
        check_read("read_reg5_after", 5'd1, 5'd5, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_id_status();
        test_ctrl_selfclear();
        test_foreign_phy();
        test_short_preamble();
        test_bad_op();
        test_reset_mid_read();
        test_reset_mid_write();
        repeat (20) @(posedge clk);
        vectors = vectors + 1;
        if (wr_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL wr_queue_drain: %0d commits missing, required 0", wr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- Clause-22 MDIO management responder (PHY side), the counterpart of the Ethernet MAC MDIO master.
- Decodes MDC/MDIO frames and serves reads and writes to a small PHY register set.
- Reports each committed write to fabric logic.
- Used as a PHY management model for on-board bring-up and in system simulation of the Ethernet subsystem.

Parameters:
PHY_ADDR, 5'd1, PHYAD this responder answers to
PRE_LEN, 32, consecutive 1 bits required before ST (range 1..32)
PHY_ID1, 16'h0022, read-only value of register 2
PHY_ID2, 16'h1556, read-only value of register 3
CTRL_RST, 16'h1140, reset value of register 0

Ports:
clk_clk  input  1  system clock; must be at least 8x MDC frequency
reset_reset  input  1  synchronous, active-high reset
mdio_mdc  input  1  MDC from master, asynchronous to clk_clk
mdio_mdio_in  input  1  MDIO pad input, asynchronous
mdio_mdio_out  output  1  MDIO drive value
mdio_mdio_oen  output  1  output enable, active low (0 = drive, 1 = release)
status_in  input  16  live value returned for register 1
ctrl_out  output  16  current register 0 contents
wr_pulse  output  1  one-clk pulse on each committed write frame to PHY_ADDR
wr_regad  output  5  REGAD of the last write
wr_data  output  16  data of the last write
frame_err  output  1  one-clk pulse when a frame is aborted for bad ST/OP

Behaviour:
- Reset values: mdio_mdio_out=1, mdio_mdio_oen=1, ctrl_out=CTRL_RST, wr_pulse=0, wr_regad=0, wr_data=0, frame_err=0, registers 4..7 = 0, FSM=PRE, preamble count=0.
- Synchronisation: mdio_mdc and mdio_mdio_in each pass through 2 flops. An MDC rising edge is detected from synced MDC (prev 0, now 1) and produces a 1-clk strobe, 3 clk after the pin edge. All sampling and all output changes occur only on that strobe.
- Registers:
  - 0: R/W. Bit15 self-clears: a write with bit15=1 loads CTRL_RST one clk after the commit.
  - 1: status_in, captured when REGAD completes.
  - 2: PHY_ID1. 3: PHY_ID2. Writes to 1..3 are ignored.
  - 4..7: R/W scratch.
  - 8..31: read 0, writes ignored.
  - wr_pulse fires for any write frame to PHY_ADDR, whatever the REGAD.
- FSM, one bit per strobe:
  - PRE: count sampled 1s, saturating at PRE_LEN. A 0 with count>=PRE_LEN -> ST2. A 0 with count<PRE_LEN -> clear count, stay in PRE.
  - ST2: expect 1 -> OP. 0 -> frame_err, clear count, back to PRE.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 -> frame_err, back to PRE.
  - PHYAD: 5 bits, MSB first. Then REGAD: 5 bits, MSB first.
  - On the last REGAD bit: latch the read word. On PHYAD mismatch go to SKIP, which ignores 18 bits and never drives, then returns to PRE.
  - TA, read: on the strobe of TA bit 1 set oen=0, out=0. On each of the next 16 strobes present data MSB first (RD, 16 bits). On the strobe after the 16th bit: oen=1, out=1 -> PRE.
  - TA, write: ignore 2 bits. Then WR: shift 16 bits. On the 16th bit commit to the register file, pulse wr_pulse, update wr_regad/wr_data -> PRE.
- After any frame the preamble count restarts at 0, so back-to-back frames each need PRE_LEN ones.
- Reset mid-frame: next clk all outputs return to reset values and the bus is released immediately. A partial write is never committed.
- MDC stopped mid-frame: the FSM holds its state; there is no timeout.
- A clk where a commit and a bit15 self-clear coincide: the self-clear wins.

Test Plan:
- 32 ones, then write frame PHYAD=1, REGAD=4, data 16'hA55A; then read REGAD 4 -> wr_pulse once, wr_regad=4, wr_data=A55A; read drives 0 at TA then A55A MSB first; oen=1 after the 16th bit.
- Read REGAD 2 and REGAD 3 -> 16'h0022 and 16'h1556. Read REGAD 1 with status_in=16'h796D -> 796D. Read REGAD 20 -> 0000.
- Write REGAD 0 data 16'h9140 -> ctrl_out=9140 for one clk, then 1140.
- Read frame to PHYAD=5 -> oen stays 1 for the whole frame and the following frame to PHYAD=1 is served normally. Preamble of 31 ones -> frame ignored, no drive.
- OP=11 after a valid preamble -> one frame_err pulse, no drive, no write.
- reset_reset asserted at RD bit 7 -> oen=1 next clk. A write frame cut by reset at WR bit 10 leaves register 5 unchanged.
